// File: rtl/config_broadcaster_if.sv
// Host byte stream plus reconfiguration bus of the config broadcaster.
// master = host / bus observer side, slave = broadcaster side.
interface config_broadcaster_if;
    logic       start_reconfig;
    logic       end_reconfig;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tracing;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       busy;
    logic       error;

    modport master (
        output start_reconfig, end_reconfig, in_valid, in_data,
        input  in_ready, tracing, configId, configData, busy, error
    );

    modport slave (
        input  start_reconfig, end_reconfig, in_valid, in_data,
        output in_ready, tracing, configId, configData, busy, error
    );
endinterface

// File: rtl/config_broadcaster.sv
// Transmit side of the instrumentation reconfiguration bus. Receives host
// frames (ID, 16-bit big-endian length, payload), buffers the payload and
// replays it as a gap-free run of one byte per cycle on configId/configData.
// Owns the global tracing signal. All outputs come straight from flops.
module config_broadcaster #(
    parameter int         MAX_PAYLOAD  = 256,
    parameter logic [7:0] IDLE_ID      = 8'hFF,
    parameter int         DRAIN_CYCLES = 8,
    parameter int         GAP_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    config_broadcaster_if.slave  bus
);
    localparam int PW = $clog2(MAX_PAYLOAD + 1);
    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    typedef enum logic [3:0] {
        TRACE, DRAIN, HDR_ID, HDR_LEN_HI, HDR_LEN_LO, LOAD, DISCARD, SEND, GAP
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   len_q, len_d;
    logic [7:0]    tgt_q, tgt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          in_ready_q, in_ready_d;
    logic          tracing_q, tracing_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
    logic [7:0]    cfg_id_q, cfg_id_d;
    logic [7:0]    cfg_data_q, cfg_data_d;

    logic [7:0]    mem_q [MAX_PAYLOAD];
    logic          mem_we;
    logic          accept;
    logic [15:0]   new_len;
    logic [7:0]    rd_byte;

    assign accept  = bus.in_valid & in_ready_q;
    assign new_len = {len_q[15:8], bus.in_data};

    // Next-state, counters and pointers; outputs are derived from state_d
    // so that every registered output lines up with the registered state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        tgt_d    = tgt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        error_d  = error_q;
        mem_we   = 1'b0;
        case (state_q)
            TRACE: begin
                if (bus.start_reconfig) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                    error_d = 1'b0;
                end
            end
            DRAIN: begin
                if (cnt_q == 16'(DRAIN_CYCLES - 1)) begin
                    state_d  = HDR_ID;
                    wr_ptr_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HDR_ID: begin
                wr_ptr_d = '0;
                // A byte arriving with end_reconfig takes priority.
                if (accept) begin
                    tgt_d   = bus.in_data;
                    state_d = HDR_LEN_HI;
                end else if (bus.end_reconfig) begin
                    state_d = TRACE;
                end
            end
            HDR_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = bus.in_data;
                    state_d     = HDR_LEN_LO;
                end
            end
            HDR_LEN_LO: begin
                if (accept) begin
                    len_d = new_len;
                    cnt_d = '0;
                    if (new_len == 16'd0) begin
                        state_d = GAP;
                    end else if (new_len > 16'(MAX_PAYLOAD)) begin
                        error_d = 1'b1;
                        state_d = DISCARD;
                    end else begin
                        wr_ptr_d = '0;
                        state_d  = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (16'(wr_ptr_q) + 16'd1 == len_q) begin
                        rd_ptr_d = '0;
                        state_d  = SEND;
                    end
                end
            end
            DISCARD: begin
                if (accept) begin
                    if (cnt_q + 16'd1 == len_q) begin
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            SEND: begin
                if (16'(rd_ptr_q) + 16'd1 == len_q) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == 16'(GAP_CYCLES - 1)) begin
                    wr_ptr_d = '0;
                    state_d  = HDR_ID;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = TRACE;
        endcase
    end

    // Byte for the next SEND cycle. With L==1 the only byte is being
    // written on the same edge that enters SEND, so forward it directly.
    always_comb begin
        rd_byte = mem_q[rd_ptr_d[AW-1:0]];
        if (mem_we && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            rd_byte = bus.in_data;
        end
    end

    // Output values for the next cycle, keyed on the next state.
    always_comb begin
        in_ready_d = (state_d == HDR_ID) || (state_d == HDR_LEN_HI) ||
                     (state_d == HDR_LEN_LO) || (state_d == LOAD) ||
                     (state_d == DISCARD);
        tracing_d  = (state_d == TRACE);
        busy_d     = (state_d != TRACE);
        cfg_id_d   = (state_d == SEND) ? tgt_d : IDLE_ID;
        cfg_data_d = (state_d == SEND) ? rd_byte : 8'h00;
    end

    // State, control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TRACE;
            cnt_q      <= '0;
            len_q      <= '0;
            tgt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b0;
            tracing_q  <= 1'b1;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            cfg_id_q   <= IDLE_ID;
            cfg_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            tgt_q      <= tgt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
            tracing_q  <= tracing_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            cfg_id_q   <= cfg_id_d;
            cfg_data_q <= cfg_data_d;
        end
    end

    // Payload buffer; contents need no reset since every frame rewrites
    // all bytes it later replays.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.tracing    = tracing_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;
    assign bus.configId   = cfg_id_q;
    assign bus.configData = cfg_data_q;
endmodule

// File: tb/tb_config_broadcaster.sv
// Directed bench for config_broadcaster: one task per scenario, inputs
// driven and outputs sampled on the falling edge.
module tb_config_broadcaster;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    config_broadcaster_if bus ();

    config_broadcaster dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Model receiver: records every non-idle byte with its position in the
    // current run (counter advances each cycle an ID is present, clears on idle).
    logic [7:0] cap_id[$];
    logic [7:0] cap_dat[$];
    int         cap_pos[$];
    int         runs = 0;
    int         idle_run = 0;
    int         min_gap = 1000;

    initial begin
        int pos;
        pos = 0;
        forever begin
            @(negedge clk);
            if (bus.configId === 8'hFF) begin
                pos = 0;
                idle_run++;
            end else begin
                if (pos == 0) begin
                    runs++;
                    if (idle_run < min_gap) min_gap = idle_run;
                end
                cap_id.push_back(bus.configId);
                cap_dat.push_back(bus.configData);
                cap_pos.push_back(pos);
                pos++;
                idle_run = 0;
            end
        end
    end

    task automatic clear_cap();
        cap_id.delete();
        cap_dat.delete();
        cap_pos.delete();
    endtask

    // Present one byte and hold it until accepted.
    task automatic put(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL put_timeout byte=%02h never accepted", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.tracing !== 1'b1) begin errors++; $display("FAIL reset_tracing got=%b exp=1", bus.tracing); end
        checks++; if (bus.configId !== 8'hFF) begin errors++; $display("FAIL reset_configId got=%02h exp=ff", bus.configId); end
        checks++; if (bus.configData !== 8'h00) begin errors++; $display("FAIL reset_configData got=%02h exp=00", bus.configData); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", bus.error); end
        // end_reconfig in TRACE must be ignored
        bus.end_reconfig = 1'b1;
        @(negedge clk);
        bus.end_reconfig = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.tracing !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL trace_hold tracing=%b busy=%b exp 1/0", bus.tracing, bus.busy); end
    endtask

    // Pulse start_reconfig and measure the drain window until in_ready.
    task automatic test_drain();
        int n;
        bus.start_reconfig = 1'b1;
        @(negedge clk);
        bus.start_reconfig = 1'b0;
        checks++; if (bus.tracing !== 1'b0) begin errors++; $display("FAIL drain_tracing got=%b exp=0", bus.tracing); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL drain_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL drain_error got=%b exp=0", bus.error); end
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            checks++; if (bus.configId !== 8'hFF) begin errors++; $display("FAIL drain_id got=%02h exp=ff", bus.configId); end
            @(negedge clk);
            n++;
        end
        checks++; if (n != 8) begin errors++; $display("FAIL drain_len got=%0d cycles exp=8", n); end
    endtask

    task automatic test_frame_stall();
        logic [7:0] exp[4];
        exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        clear_cap();
        put(8'h03); put(8'h00); put(8'h04);
        put(exp[0]); repeat (3) @(negedge clk);
        put(exp[1]); repeat (3) @(negedge clk);
        put(exp[2]); repeat (3) @(negedge clk);
        checks++; if (cap_id.size() != 0) begin errors++; $display("FAIL stall_early_emit got=%0d bytes exp=0", cap_id.size()); end
        put(exp[3]);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.configId !== 8'h03 || bus.configData !== exp[k] || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL send_byte%0d got id=%02h d=%02h rdy=%b exp id=03 d=%02h rdy=0", k, bus.configId, bus.configData, bus.in_ready, exp[k]);
            end
            @(negedge clk);
        end
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (bus.configId !== 8'hFF || bus.configData !== 8'h00 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL gap%0d got id=%02h d=%02h rdy=%b exp ff/00/0", g, bus.configId, bus.configData, bus.in_ready);
            end
            @(negedge clk);
        end
        checks++; if (bus.in_ready !== 1'b1 || bus.configId !== 8'hFF) begin errors++; $display("FAIL hdr_after_gap rdy=%b id=%02h exp 1/ff", bus.in_ready, bus.configId); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d[4];
        int         exp_p[4];
        int         runs0;
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_p = '{0, 1, 2, 0};
        clear_cap();
        runs0   = runs;
        min_gap = 1000;
        put(8'h02); put(8'h00); put(8'h03); put(8'h11); put(8'h22); put(8'h33);
        put(8'h02); put(8'h00); put(8'h01); put(8'h44);
        repeat (8) @(negedge clk);
        checks++; if (cap_id.size() != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", cap_id.size()); end
        checks++; if (runs - runs0 != 2) begin errors++; $display("FAIL b2b_runs got=%0d exp=2", runs - runs0); end
        checks++; if (min_gap < 2) begin errors++; $display("FAIL b2b_gap got=%0d exp>=2", min_gap); end
        for (int i = 0; i < 4 && i < cap_id.size(); i++) begin
            checks++;
            if (cap_id[i] !== 8'h02 || cap_dat[i] !== exp_d[i] || cap_pos[i] != exp_p[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d got id=%02h d=%02h pos=%0d exp id=02 d=%02h pos=%0d", i, cap_id[i], cap_dat[i], cap_pos[i], exp_d[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_oversize();
        clear_cap();
        put(8'h01); put(8'h01); put(8'h01);
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL over_error got=%b exp=1", bus.error); end
        for (int i = 0; i < 257; i++) put(8'(i));
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL over_consumed rdy=%b exp=0 after 257 bytes", bus.in_ready); end
        checks++; if (cap_id.size() != 0) begin errors++; $display("FAIL over_emit got=%0d bytes exp=0", cap_id.size()); end
        put(8'h04); put(8'h00); put(8'h02); put(8'h5A); put(8'hA5);
        repeat (6) @(negedge clk);
        checks++; if (cap_id.size() != 2) begin errors++; $display("FAIL over_next_count got=%0d exp=2", cap_id.size()); end
        if (cap_id.size() == 2) begin
            checks++; if (cap_id[0] !== 8'h04 || cap_dat[0] !== 8'h5A) begin errors++; $display("FAIL over_next0 got %02h/%02h exp 04/5a", cap_id[0], cap_dat[0]); end
            checks++; if (cap_id[1] !== 8'h04 || cap_dat[1] !== 8'hA5) begin errors++; $display("FAIL over_next1 got %02h/%02h exp 04/a5", cap_id[1], cap_dat[1]); end
        end
        checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL over_sticky got=%b exp=1", bus.error); end
    endtask

    task automatic test_zero_len();
        clear_cap();
        put(8'h05); put(8'h00); put(8'h00);
        checks++; if (bus.in_ready !== 1'b0 || bus.configId !== 8'hFF) begin errors++; $display("FAIL zero_gap0 rdy=%b id=%02h exp 0/ff", bus.in_ready, bus.configId); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero_gap1 rdy=%b exp=0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL zero_hdr rdy=%b exp=1", bus.in_ready); end
        bus.end_reconfig = 1'b1;
        @(negedge clk);
        bus.end_reconfig = 1'b0;
        checks++; if (bus.tracing !== 1'b1) begin errors++; $display("FAIL end_tracing got=%b exp=1", bus.tracing); end
        checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL end_busy busy=%b rdy=%b exp 0/0", bus.busy, bus.in_ready); end
        checks++; if (cap_id.size() != 0) begin errors++; $display("FAIL zero_emit got=%0d bytes exp=0", cap_id.size()); end
    endtask

    task automatic test_reset_mid_send();
        repeat (3) @(negedge clk);
        test_drain();
        put(8'h07); put(8'h00); put(8'h08);
        for (int i = 0; i < 8; i++) put(8'h10 + 8'(i));
        checks++; if (bus.configId !== 8'h07 || bus.configData !== 8'h10) begin errors++; $display("FAIL mid_send0 got %02h/%02h exp 07/10", bus.configId, bus.configData); end
        @(negedge clk);
        checks++; if (bus.configData !== 8'h11) begin errors++; $display("FAIL mid_send1 got %02h exp 11", bus.configData); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.tracing !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset tracing=%b busy=%b exp 1/0", bus.tracing, bus.busy); end
        checks++; if (bus.configId !== 8'hFF || bus.configData !== 8'h00) begin errors++; $display("FAIL mid_reset_bus got %02h/%02h exp ff/00", bus.configId, bus.configData); end
        repeat (3) @(negedge clk);
        checks++; if (bus.configId !== 8'hFF) begin errors++; $display("FAIL mid_reset_quiet got %02h exp ff", bus.configId); end
        clear_cap();
        test_drain();
        put(8'h07); put(8'h00); put(8'h08);
        for (int i = 0; i < 8; i++) put(8'h80 + 8'(i));
        repeat (12) @(negedge clk);
        checks++; if (cap_id.size() != 8) begin errors++; $display("FAIL replay_count got=%0d exp=8", cap_id.size()); end
        for (int i = 0; i < 8 && i < cap_id.size(); i++) begin
            checks++;
            if (cap_id[i] !== 8'h07 || cap_dat[i] !== 8'h80 + 8'(i) || cap_pos[i] != i) begin
                errors++;
                $display("FAIL replay_byte%0d got id=%02h d=%02h pos=%0d exp id=07 d=%02h pos=%0d", i, cap_id[i], cap_dat[i], cap_pos[i], 8'h80 + 8'(i), i);
            end
        end
    endtask

    initial begin
        bus.start_reconfig = 1'b0;
        bus.end_reconfig   = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = 8'h00;
        reset              = 1'b1;
        @(negedge clk);
        test_reset();
        test_drain();
        test_frame_stall();
        test_back_to_back();
        test_oversize();
        test_zero_len();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/config_broadcaster.md
Name: config_broadcaster

Overview:
- Transmit side of the instrumentation reconfiguration bus (tracing / configId / configData) that every building block listens on.
- Accepts host frames over a valid/ready byte stream: target ID, 16-bit length, payload.
- Buffers the whole payload, then streams it as an unbroken run of one byte per cycle. Receivers advance their byte counter every cycle their ID is present, so a gap inside a run would corrupt them.
- Owns the global tracing signal: drops it for reconfiguration and restores it on host request.

Parameters:
- MAX_PAYLOAD, 256: payload buffer depth in bytes; largest legal frame length.
- IDLE_ID, 8'hFF: configId driven when no block is addressed; never a block's PERSONAL_CONFIG_ID.
- DRAIN_CYCLES, 8: cycles after tracing falls before the first input byte is accepted, so trace pipelines empty.
- GAP_CYCLES, 2: minimum IDLE_ID cycles after every frame run; receivers clear their counters here.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start_reconfig  input  1  pulse; request to leave tracing
- end_reconfig  input  1  pulse; request to resume tracing
- in_valid  input  1  host byte valid
- in_data  input  8  host byte
- in_ready  output  1  byte accepted when in_valid & in_ready
- tracing  output  1  1 = tracing, 0 = reconfiguring
- configId  output  8  addressed block ID or IDLE_ID
- configData  output  8  payload byte
- busy  output  1  high in any state except TRACE
- error  output  1  sticky oversize-frame flag; cleared by reset or start_reconfig

Behaviour:
- All outputs are registered.
- Reset (synchronous, takes effect at any state including mid-SEND):
  - State TRACE; tracing=1, configId=IDLE_ID, configData=0, in_ready=0, busy=0, error=0.
  - Buffer pointers, length register and counters cleared. A partially sent run is abandoned.
- States: TRACE, DRAIN, HDR_ID, HDR_LEN_HI, HDR_LEN_LO, LOAD, DISCARD, SEND, GAP.
- TRACE:
  - start_reconfig -> DRAIN; tracing=0 from the next cycle.
  - end_reconfig is ignored in this state.
- DRAIN: counts DRAIN_CYCLES cycles, then -> HDR_ID.
- HDR_ID:
  - in_ready=1. An accepted byte is latched as the target ID -> HDR_LEN_HI.
  - end_reconfig while no byte is accepted that cycle -> TRACE; tracing=1 the next cycle.
  - If a byte and end_reconfig arrive in the same cycle, the byte wins and end_reconfig is dropped.
- HDR_LEN_HI, HDR_LEN_LO: in_ready=1; latch the big-endian length L. After the LO byte:
  - L==0 -> GAP.
  - L>MAX_PAYLOAD -> error=1, then DISCARD.
  - Otherwise -> LOAD.
- LOAD:
  - in_ready=1. Bytes are written to the buffer at wr_ptr, wr_ptr++.
  - The cycle the L-th byte is accepted -> SEND.
  - Host stalls (in_valid=0) are allowed and have no effect on outputs.
- DISCARD: in_ready=1; consume and drop L bytes -> GAP. Nothing is emitted on configId.
- SEND:
  - Exactly L consecutive cycles with configId=target ID and configData=buffer[k] on cycle k (k=0..L-1). The byte is aligned with configId in the same cycle.
  - in_ready=0. No stall is possible.
  - After the last byte -> GAP.
- GAP:
  - configId=IDLE_ID, configData=0 for GAP_CYCLES cycles, then -> HDR_ID.
  - Two consecutive frames with the same ID are therefore always separated.
- tracing stays 0 from DRAIN through GAP. Only the HDR_ID + end_reconfig exit raises it.
- start_reconfig outside TRACE is ignored. Input bytes are accepted only in HDR_*, LOAD and DISCARD.
- Buffer: single-port register array MAX_PAYLOAD x 8. Read pointer restarts at 0 on each SEND; wr_ptr resets at HDR_ID.
- Width rules:
  - Length counter is 16 bits.
  - Pointers are $clog2(MAX_PAYLOAD+1) bits wide. L==MAX_PAYLOAD is legal and fills the buffer exactly, with no wrap.

Test Plan:
- Reset, then start_reconfig at cycle 5 -> tracing=0 at cycle 6; in_ready first high at cycle 6+DRAIN_CYCLES=14; configId=8'hFF throughout.
- Frame {8'h03, 8'h00, 8'h04, A1, B2, C3, D4} with 3-cycle host stalls inside the payload -> configId=8'h03 for exactly 4 consecutive cycles carrying A1, B2, C3, D4; then 2 cycles of 8'hFF.
- Back-to-back frames to ID 2 (L=3) and ID 2 (L=1) -> two separate runs split by 2 IDLE cycles; a model receiver sees counters 0-2 and then 0.
- Frame {8'h01, 8'h01, 8'h01, ...257 bytes} with MAX_PAYLOAD=256 -> error=1; all 257 bytes consumed; configId stays 8'hFF; the next valid frame is sent correctly.
- Frame with L=0 to ID 5 -> no cycle with configId=5; GAP, then HDR_ID. end_reconfig afterwards -> tracing=1 the next cycle, busy=0.
- reset asserted on the 2nd SEND cycle of an L=8 frame -> next cycle tracing=1, configId=8'hFF, busy=0. A fresh reconfiguration then replays a full frame without stale bytes.
